// File: rtl/tff_bank_arbiter.sv
// tff_bank_arbiter: round-robin arbiter sharing one WIDTH-bit toggle flip-flop bank among NUM_REQ requesters
//   clk_in           clock, all state updates on posedge
//   reset_in         asynchronous active-high reset
//   clear_in         synchronous clear of bank and counter, wins over grants
//   req_in/mask_in   per-requester request and toggle mask (requester i at [i*WIDTH +: WIDTH])
//   ack_out          one-hot pulse, mask of that requester applied at preceding edge
//   q_out            bank state
//   busy_out         any eligible request pending (combinational)
//   toggle_count_out saturating count of bank bits toggled since reset/clear
module tff_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     clear_in,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*WIDTH-1:0] mask_in,
  output logic [NUM_REQ-1:0]       ack_out,
  output logic [WIDTH-1:0]         q_out,
  output logic                     busy_out,
  output logic [CNT_W-1:0]         toggle_count_out
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr, win;
  logic found;
  logic [NUM_REQ-1:0] elig;
  logic [WIDTH-1:0] win_mask;
  logic [CNT_W:0] sum;
  logic [CNT_W-1:0] cnt_nxt;
  int idx;
  // a requester whose ack is showing is being retired this cycle, so it must not win again
  assign elig = req_in & ~ack_out;
  assign busy_out = |elig;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      if (!found && elig[PW'(idx)]) begin
        found = 1'b1;
        win = PW'(idx);
      end
    end
  end
  always_comb begin
    win_mask = '0;
    for (int i = 0; i < NUM_REQ; i++)
      win_mask = PW'(i) == win ? mask_in[i*WIDTH +: WIDTH] : win_mask;
  end
  // one extra bit catches the carry so the count clamps instead of wrapping
  assign sum = {1'b0, toggle_count_out} + (CNT_W+1)'($countones(win_mask));
  assign cnt_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      q_out <= '0;
      ack_out <= '0;
      toggle_count_out <= '0;
      ptr <= '0;
    end else if (clear_in) begin
      q_out <= '0;
      ack_out <= '0;
      toggle_count_out <= '0;
    end else if (found) begin
      q_out <= q_out ^ win_mask;
      ack_out <= NUM_REQ'(1) << win;
      toggle_count_out <= cnt_nxt;
      ptr <= win == PW'(NUM_REQ-1) ? '0 : win + 1'b1;
    end else begin
      ack_out <= '0;
    end
  end
endmodule

// File: tb/tb_tff_bank_arbiter.sv
// tb_tff_bank_arbiter: directed and random checks of tff_bank_arbiter against a behavioural model
module tb_tff_bank_arbiter;
  logic clk_in = 1'b0;
  logic reset_in, clear_in;
  logic [3:0] req;
  logic [31:0] mask;
  logic [3:0] ack, ack_s;
  logic [7:0] q, q_s;
  logic busy, busy_s;
  logic [15:0] cnt;
  logic [3:0] cnt_s;
  int n_assert = 0, n_fail = 0;
  logic [7:0] m_q;
  logic [3:0] m_ack;
  int m_ptr, m_cnt;

  tff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8), .CNT_W(16)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .clear_in(clear_in), .req_in(req), .mask_in(mask),
    .ack_out(ack), .q_out(q), .busy_out(busy), .toggle_count_out(cnt));
  tff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8), .CNT_W(4)) dut_s (
    .clk_in(clk_in), .reset_in(reset_in), .clear_in(clear_in), .req_in(req), .mask_in(mask),
    .ack_out(ack_s), .q_out(q_s), .busy_out(busy_s), .toggle_count_out(cnt_s));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("q", 32'(q), 32'(m_q));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("cnt", 32'(cnt), m_cnt > 65535 ? 65535 : m_cnt);
    chk("q_small", 32'(q_s), 32'(m_q));
    chk("ack_small", 32'(ack_s), 32'(m_ack));
    chk("cnt_small", 32'(cnt_s), m_cnt > 15 ? 15 : m_cnt);
  endtask

  task automatic step();
    int w;
    logic [3:0] elig;
    logic [7:0] m;
    #1;
    elig = req & ~m_ack;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    chk("busy", 32'(busy), 32'(|elig));
    chk("busy_small", 32'(busy_s), 32'(|elig));
    @(posedge clk_in);
    #1;
    if (clear_in) begin
      m_q = '0;
      m_cnt = 0;
      m_ack = '0;
    end else if (w >= 0) begin
      m = mask[w*8 +: 8];
      m_q ^= m;
      m_cnt += $countones(m);
      m_ack = 4'b1 << w;
      m_ptr = (w + 1) % 4;
    end else begin
      m_ack = '0;
    end
    check_state();
  endtask

  task automatic do_reset();
    #2 reset_in = 1'b1;
    #1;
    m_q = '0;
    m_ack = '0;
    m_cnt = 0;
    m_ptr = 0;
    check_state();
    @(posedge clk_in);
    #1 reset_in = 1'b0;
  endtask

  function automatic logic [7:0] rmask();
    return $urandom_range(3) == 0 ? 8'h00 : 8'($urandom);
  endfunction

  initial begin
    reset_in = 1'b1;
    clear_in = 1'b0;
    req = '0;
    mask = '0;
    do_reset();
    // single requester, then the same mask again to toggle back
    req = 4'b0001;
    mask = 32'h0000_000F;
    step();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_q", 32'(q), 32'h0F);
    chk("t1_cnt", 32'(cnt), 4);
    step();
    chk("t1_gap_ack", 32'(ack), 32'h0);
    step();
    chk("t1_q2", 32'(q), 32'h00);
    chk("t1_cnt2", 32'(cnt), 8);
    req = '0;
    step();
    // all four held high: back-to-back round robin
    do_reset();
    req = 4'b1111;
    mask = 32'h0804_0201;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_order", 32'(ack), 32'(4'b1 << (i % 4)));
      if (i == 3) chk("t2_q", 32'(q), 32'h0F);
    end
    // requester 2 holds req through its ack
    do_reset();
    req = 4'b0100;
    mask = 32'h0011_0000;
    step();
    chk("t3_ack1", 32'(ack), 32'h4);
    step();
    chk("t3_noregrant", 32'(ack), 32'h0);
    step();
    chk("t3_ack2", 32'(ack), 32'h4);
    // clear while requests pending
    req = '0;
    do_reset();
    req = 4'b0001;
    mask = 32'h0000_00AA;
    step();
    chk("t4_q_pre", 32'(q), 32'hAA);
    req = 4'b0011;
    mask = 32'h0000_3CAA;
    clear_in = 1'b1;
    step();
    chk("t4_clr_q", 32'(q), 32'h0);
    chk("t4_clr_ack", 32'(ack), 32'h0);
    chk("t4_clr_cnt", 32'(cnt), 0);
    clear_in = 1'b0;
    step();
    chk("t4_after_ack", 32'(ack), 32'h2);
    chk("t4_after_q", 32'(q), 32'h3C);
    // saturation on the CNT_W=4 instance, then a zero mask
    req = '0;
    do_reset();
    mask = 32'h0000_FFFF;
    req = 4'b0001;
    step();
    chk("t5_cnt8", 32'(cnt_s), 8);
    req = 4'b0010;
    step();
    chk("t5_sat", 32'(cnt_s), 15);
    chk("t5_wide", 32'(cnt), 16);
    req = 4'b0100;
    step();
    chk("t5_zero_ack", 32'(ack_s), 32'h4);
    chk("t5_zero_q", 32'(q_s), 32'h00);
    chk("t5_zero_cnt", 32'(cnt_s), 15);
    // async reset while grants are active
    req = 4'b1111;
    mask = 32'h8040_2010;
    step();
    step();
    do_reset();
    step();
    chk("t6_first", 32'(ack), 32'h1);
    // random traffic following the requester protocol
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(1) == 1) req[i] = 1'b0;
          else mask[i*8 +: 8] = rmask();
        end else if (req[i]) begin
          if ($urandom_range(9) == 0) req[i] = 1'b0;
        end else if ($urandom_range(9) < 4) begin
          req[i] = 1'b1;
          mask[i*8 +: 8] = rmask();
        end
      end
      clear_in = $urandom_range(19) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
